// File: rtl/cordic_phase_prep.sv
// Phase accumulator and quadrant fold feeding a sine/cosine CORDIC rotator.
// It also delays the flip and valid flags so they line up with the rotator's outputs.
module cordic_phase_prep #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 16,
  parameter int X_INIT  = 19896
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [31:0]             phase_inc,
  input  logic                    phase_load,
  input  logic [31:0]             phase_load_val,
  output logic signed [WIDTH-1:0] x_start,
  output logic signed [WIDTH-1:0] y_start,
  output logic signed [31:0]      angle,
  output logic                    flip,
  output logic                    angle_valid,
  output logic                    flip_aligned,
  output logic                    valid_aligned
);

  logic [31:0]        acc_p0;
  logic signed [31:0] angle_p1;
  logic               flip_p1;
  logic               vld_p1;
  logic [LATENCY-1:0] flip_dly;
  logic [LATENCY-1:0] vld_dly;

  // Phases in 90..270 deg are shifted by 180 deg into the rotator's range.
  // The rotator output is then negated via flip. Returns {flip, angle}.
  function automatic logic [32:0] fold(input logic [31:0] a);
    logic f;
    f = a[31] ^ a[30];
    return {f, a[31] ^ f, a[30:0]};
  endfunction

  assign x_start = WIDTH'(X_INIT);
  assign y_start = '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_p0   <= '0;
      angle_p1 <= '0;
      flip_p1  <= 1'b0;
      vld_p1   <= 1'b0;
      flip_dly <= '0;
      vld_dly  <= '0;
    end else begin
      // p0: phase accumulator, load wins over advance
      if (phase_load)
        acc_p0 <= phase_load_val;
      else if (enable)
        acc_p0 <= acc_p0 + phase_inc;
      // p1: folded angle of the accumulator value presented this cycle
      {flip_p1, angle_p1} <= fold(acc_p0);
      vld_p1              <= enable;
      // p1 -> p1+LATENCY: flag delay lines matching the rotator pipeline
      flip_dly[0] <= flip_p1;
      vld_dly[0]  <= vld_p1;
      for (int i = 1; i < LATENCY; i++) begin
        flip_dly[i] <= flip_dly[i-1];
        vld_dly[i]  <= vld_dly[i-1];
      end
    end
  end

  assign angle         = angle_p1;
  assign flip          = flip_p1;
  assign angle_valid   = vld_p1;
  assign flip_aligned  = flip_dly[LATENCY-1];
  assign valid_aligned = vld_dly[LATENCY-1];

endmodule

// File: doc/cordic_phase_prep.md
# cordic_phase_prep

Phase-accumulator and quadrant-folding front end for the 16-stage sine/cosine CORDIC rotator. Each cycle it advances a 32-bit phase (2^32 = 360°) and folds it into the rotator's convergent range of ±90°. It presents the rotator's `x_start`, `y_start` and `angle` inputs, plus a `flip` flag that tells the output stage to negate both sine and cosine. `valid` and `flip` are also delay-matched to the rotator's pipeline, so a downstream stage can pick up both flags aligned with `sine`/`cosine`.

## Interface
- `WIDTH`, 16: data width of `x_start`/`y_start`; matches the rotator's `width`.
- `LATENCY`, 16: rotator latency in cycles from its inputs to `sine`/`cosine`.
- `X_INIT`, 19896: gain-precompensated start vector, ≈0.6072×32767, with margin for rounding growth.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  advance phase by `phase_inc`; marks this cycle's output valid.
- `phase_inc`  in  32  frequency word, unsigned, mod 2^32.
- `phase_load`  in  1  load accumulator with `phase_load_val`; priority over `enable`.
- `phase_load_val`  in  32  phase value to load.
- `x_start`  out  WIDTH  constant `X_INIT`; not registered, unaffected by reset.
- `y_start`  out  WIDTH  constant 0.
- `angle`  out  32  signed folded angle, 0x20000000 = 45°.
- `flip`  out  1  1 = negate rotator outputs for this `angle`.
- `angle_valid`  out  1  `angle`/`flip` came from an enabled cycle.
- `flip_aligned`  out  1  `flip` delayed `LATENCY` cycles.
- `valid_aligned`  out  1  `angle_valid` delayed `LATENCY` cycles.

## Operation
- **Accumulator `acc` (32 bits), update priority:**
  - `reset`: `acc` <= 0.
  - else if `phase_load`: `acc` <= `phase_load_val`.
  - else if `enable`: `acc` <= `acc` + `phase_inc`, wrapping mod 2^32.
  - else: hold.
- **Fold on `acc[31:30]`:**
  - 00 or 11 (−90°..<90°): `angle` = `acc`, `flip` = 0.
  - 01 or 10 (90°..<270°): `angle` = `acc` with bit 31 inverted (i.e. −180°), `flip` = 1.
  - 0x40000000 (90°) maps to 0xC0000000 with `flip` = 1. Output is sin = +1; no special case.
- **Output register:** updated every non-reset cycle.
  - `angle`, `flip` <= fold(current `acc`).
  - `angle_valid` <= `enable`.
- **Delay line:** two `LATENCY`-deep shift registers carry `flip` and `angle_valid`, and shift every cycle.
- **Reset:** `angle` = 0, `flip` = 0, `angle_valid` = 0, and both delay lines are cleared. After reset, `flip_aligned` = `valid_aligned` = 0 for `LATENCY` cycles.
- **`enable` low:** `acc` holds. `angle` keeps showing fold(`acc`) with `angle_valid` = 0.
- **`phase_load` and `enable` both high:** `acc` loads and no add occurs. The next cycle's output is fold(old `acc`) with `angle_valid` = 1.

## Timing
- `acc` = A at cycle n → `angle`/`flip`/`angle_valid` reflect A and `enable`(n) at n+1.
- `phase_load` at cycle n → `acc` = V at n+1 → `angle` = fold(V) at n+2.
- `flip_aligned`/`valid_aligned` at cycle m equal `flip`/`angle_valid` at cycle m−`LATENCY`. With the rotator registering its inputs on each edge, this aligns with its `sine`/`cosine` outputs.
- Reset asserted mid-stream: every registered output is 0 on the cycle after the reset edge.
- Throughput: one sample per cycle while `enable` is high.
- No combinational path from any input to any output.

## Test plan
- **Reset:** hold `reset` 3 cycles, then release with `enable` = 0.
  - During reset and after: `angle` = 0, `flip` = 0, `angle_valid` = 0, `flip_aligned` = `valid_aligned` = 0.
  - `x_start` = 19896 and `y_start` = 0 throughout.
- **Eight-point sweep:** `phase_inc` = 0x20000000, `enable` = 1 from `acc` = 0.
  - `angle` sequence: 0x00000000, 0x20000000, 0xC0000000, 0xE0000000, 0x00000000, 0x20000000, 0xC0000000, 0xE0000000.
  - `flip` sequence: 0, 0, 1, 1, 1, 1, 0, 0.
- **Load and wrap:** load 0xF0000000, then `enable` with `phase_inc` = 0x20000000.
  - `angle` = 0xF0000000, then 0x10000000 (wrap), then 0x30000000.
  - `flip` = 0 for all three.
- **Load/enable collision and hold:**
  - `phase_load` = `enable` = 1 with `acc` = 0x20000000 → next `angle` = 0x20000000 with `angle_valid` = 1; the following cycle shows the loaded value.
  - `enable` = 0 for 5 cycles → `angle` frozen, `angle_valid` = 0.
- **Alignment:** a single `enable` pulse at `acc` = 0x60000000 → `flip_aligned` = 1 and `valid_aligned` = 1 exactly 17 cycles after the pulse (1 + `LATENCY`), for one cycle only.
- **Reset mid-operation:** assert `reset` during the sweep with the delay line full → all outputs 0 on the next cycle. `valid_aligned` stays 0 until 17 cycles after the first post-reset `enable`.
